// File: rtl/crc_pkg.sv
// Shared encodings and storage types for the CRC input path.
package crc_pkg;

    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } bus_size_t;

    typedef enum logic [1:0] {
        REV_NONE = 2'b00,
        REV_BYTE = 2'b01,
        REV_HALF = 2'b10,
        REV_WORD = 2'b11
    } rev_in_t;

    // count holds the index of the last valid byte (bytes - 1): 0, 1 or 3.
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  count;
    } entry_t;

    function automatic logic [1:0] size_to_count(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 2'd0;
            SIZE_HALF: return 2'd1;
            default:   return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/crc_bit_reverse.sv
// Input bit reversal: masks the word to the transfer width, then mirrors bits
// within groups whose size is the configured granularity clamped to the transfer size.
module crc_bit_reverse
    import crc_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  rev_in_type,
    output logic [31:0] rev_word
);

    logic [1:0]  lvl;
    logic [1:0]  gran;
    logic [31:0] masked;
    logic [31:0] rev_byte;
    logic [31:0] rev_half;
    logic [31:0] rev_full;

    always_comb begin
        case (size)
            SIZE_BYTE: begin lvl = REV_BYTE; masked = word & 32'h0000_00FF; end
            SIZE_HALF: begin lvl = REV_HALF; masked = word & 32'h0000_FFFF; end
            default:   begin lvl = REV_WORD; masked = word;                 end
        endcase
        gran = (rev_in_type > lvl) ? lvl : rev_in_type;
    end

    for (genvar i = 0; i < 32; i++) begin : g_rev
        assign rev_byte[i] = masked[(i / 8) * 8 + 7 - (i % 8)];
        assign rev_half[i] = masked[(i / 16) * 16 + 15 - (i % 16)];
        assign rev_full[i] = masked[31 - i];
    end

    always_comb begin
        case (gran)
            REV_BYTE: rev_word = rev_byte;
            REV_HALF: rev_word = rev_half;
            REV_WORD: rev_word = rev_full;
            default:  rev_word = masked;
        endcase
    end

endmodule

// File: rtl/crc_input_buffer.sv
// Two-entry CRC_DR buffer and MSB-first byte unpacker feeding the CRC unit,
// with flush handling and host back-pressure flags.
module crc_input_buffer
    import crc_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] bus_wr,
    input  logic [1:0]  bus_size,
    input  logic        buffer_write_en,
    input  logic [1:0]  rev_in_type,
    input  logic        reset_chain,
    input  logic        byte_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        crc_unit_rst,
    output logic        buffer_full,
    output logic        read_wait,
    output logic        reset_pending
);

    entry_t      mem [BUF_DEPTH];
    entry_t      head;
    entry_t      wr_entry;
    logic [31:0] rev_word;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [1:0]  idx;
    logic        drain;
    logic        rst_pulse;
    logic [7:0]  sel_byte;
    logic        complete;
    logic        last;
    logic        pop;
    logic        push;
    logic        stall;

    crc_bit_reverse u_rev (
        .word        (bus_wr),
        .size        (bus_size),
        .rev_in_type (rev_in_type),
        .rev_word    (rev_word)
    );

    assign wr_entry = '{data: rev_word, count: size_to_count(bus_size)};
    assign head     = mem[rd_ptr];

    assign byte_valid    = (count != 2'd0);
    assign read_wait     = byte_valid;
    assign buffer_full   = (count == 2'd2);
    assign reset_pending = drain;
    assign crc_unit_rst  = rst_pulse;

    assign complete = byte_valid && byte_ready;
    assign stall    = byte_valid && !byte_ready;
    assign last     = (idx == head.count);
    assign pop      = complete && last;
    assign push     = buffer_write_en && !buffer_full && !drain && !reset_chain;

    // Byte position counted from the least-significant end of the head entry.
    always_comb begin
        case (head.count - idx)
            2'd0:    sel_byte = head.data[7:0];
            2'd1:    sel_byte = head.data[15:8];
            2'd2:    sel_byte = head.data[23:16];
            default: sel_byte = head.data[31:24];
        endcase
    end

    assign byte_out = byte_valid ? sel_byte : 8'h00;

    always_ff @(posedge HCLK) begin
        if (push)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            idx       <= 2'd0;
            drain     <= 1'b0;
            rst_pulse <= 1'b0;
        end else begin
            rst_pulse <= 1'b0;
            if (reset_chain && stall) begin
                // Keep only the head so the byte in handshake can finish.
                count  <= 2'd1;
                wr_ptr <= ~rd_ptr;
                drain  <= 1'b1;
            end else if (reset_chain || (drain && complete)) begin
                count     <= 2'd0;
                rd_ptr    <= 1'b0;
                wr_ptr    <= 1'b0;
                idx       <= 2'd0;
                drain     <= 1'b0;
                rst_pulse <= 1'b1;
            end else if (!drain) begin
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop)
                    rd_ptr <= ~rd_ptr;
                if (complete)
                    idx <= last ? 2'd0 : idx + 2'd1;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_crc_input_buffer.sv
// Bench for crc_input_buffer: vector table, corner sequences and random traffic
// compared against a byte-queue model.
module tb_crc_input_buffer;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] bus_wr;
    logic [1:0]  bus_size;
    logic        buffer_write_en;
    logic [1:0]  rev_in_type;
    logic        reset_chain;
    logic        byte_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        crc_unit_rst;
    logic        buffer_full;
    logic        read_wait;
    logic        reset_pending;

    always #5 HCLK = ~HCLK;

    crc_input_buffer dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .bus_wr          (bus_wr),
        .bus_size        (bus_size),
        .buffer_write_en (buffer_write_en),
        .rev_in_type     (rev_in_type),
        .reset_chain     (reset_chain),
        .byte_ready      (byte_ready),
        .byte_out        (byte_out),
        .byte_valid      (byte_valid),
        .crc_unit_rst    (crc_unit_rst),
        .buffer_full     (buffer_full),
        .read_wait       (read_wait),
        .reset_pending   (reset_pending)
    );

    int total = 0;
    int bad   = 0;

    // Model: pending bytes in issue order, plus remaining byte count per stored entry.
    logic [7:0] mq[$];
    int         lq[$];
    logic       m_pend = 1'b0;
    logic       m_rst  = 1'b0;

    typedef struct {
        logic [31:0] wr;
        logic [1:0]  sz;
        logic [1:0]  rv;
        int          nb;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rev(input logic [31:0] w, input logic [1:0] sz, input logic [1:0] rv);
        int nb;
        int g;
        logic [31:0] v;
        logic [31:0] r;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        g  = (rv == 2'b00) ? 0 : (rv == 2'b01) ? 1 : (rv == 2'b10) ? 2 : 4;
        if (g > nb) g = nb;
        v = (nb == 4) ? w : (w & ((32'h1 << (nb * 8)) - 32'h1));
        if (g == 0) return v;
        r = 32'h0;
        for (int b = 0; b < 32; b++) begin
            int grp;
            int pos;
            grp = b / (g * 8);
            pos = b % (g * 8);
            if (((v >> b) & 32'h1) != 32'h0)
                r = r | (32'h1 << (grp * g * 8 + g * 8 - 1 - pos));
        end
        return r;
    endfunction

    task automatic model_edge();
        logic bv;
        bv    = (mq.size() != 0);
        m_rst = 1'b0;
        if (reset_chain) begin
            if (bv && !byte_ready) begin
                mq = {mq[0]};
                lq = {1};
                m_pend = 1'b1;
            end else begin
                mq.delete();
                lq.delete();
                m_pend = 1'b0;
                m_rst  = 1'b1;
            end
        end else if (m_pend) begin
            if (byte_ready) begin
                mq.delete();
                lq.delete();
                m_pend = 1'b0;
                m_rst  = 1'b1;
            end
        end else begin
            logic accept;
            accept = buffer_write_en && (lq.size() < 2);
            if (bv && byte_ready) begin
                void'(mq.pop_front());
                lq[0] = lq[0] - 1;
                if (lq[0] == 0) void'(lq.pop_front());
            end
            if (accept) begin
                logic [31:0] r;
                int nb;
                nb = (bus_size == 2'b00) ? 1 : (bus_size == 2'b01) ? 2 : 4;
                r  = model_rev(bus_wr, bus_size, rev_in_type);
                for (int k = nb - 1; k >= 0; k--)
                    mq.push_back(8'(r >> (8 * k)));
                lq.push_back(nb);
            end
        end
    endtask

    task automatic check_outputs(input string name);
        logic [12:0] exp;
        logic [12:0] act;
        exp = {(mq.size() != 0), (mq.size() != 0) ? mq[0] : 8'h00, (lq.size() == 2),
               (lq.size() != 0), m_pend, m_rst};
        act = {byte_valid, byte_out, buffer_full, read_wait, reset_pending, crc_unit_rst};
        check(name, {19'h0, act}, {19'h0, exp});
    endtask

    task automatic step(input string name);
        model_edge();
        @(posedge HCLK);
        #1;
        check_outputs(name);
    endtask

    task automatic idle_inputs();
        buffer_write_en = 1'b0;
        reset_chain     = 1'b0;
        bus_wr          = 32'h0;
        bus_size        = 2'b10;
        rev_in_type     = 2'b00;
    endtask

    task automatic drain_all();
        idle_inputs();
        byte_ready = 1'b1;
        for (int i = 0; i < 20 && (mq.size() != 0 || m_pend); i++)
            step("drain");
    endtask

    initial begin
        int n;
        int pulses;

        tbl[0] = '{32'h1234_5678, 2'b10, 2'b00, 4, 32'h1234_5678};
        tbl[1] = '{32'h0000_0001, 2'b00, 2'b01, 1, 32'h0000_0080};
        tbl[2] = '{32'h0000_0001, 2'b10, 2'b11, 4, 32'h8000_0000};
        tbl[3] = '{32'h0000_1234, 2'b01, 2'b10, 2, 32'h0000_2C48};
        tbl[4] = '{32'h0102_0304, 2'b10, 2'b01, 4, 32'h8040_C020};
        tbl[5] = '{32'hFFFF_00F1, 2'b01, 2'b01, 2, 32'h0000_008F};
        tbl[6] = '{32'hFFFF_FF35, 2'b00, 2'b11, 1, 32'h0000_00AC};
        tbl[7] = '{32'h1234_5678, 2'b10, 2'b10, 4, 32'h2C48_1E6A};
        tbl[8] = '{32'hA5A5_0F0F, 2'b11, 2'b00, 4, 32'hA5A5_0F0F};

        HRESETn = 1'b0;
        byte_ready = 1'b1;
        idle_inputs();
        #12;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        check_outputs("reset_state");

        // Vector table: one write into an empty buffer, bytes on consecutive cycles.
        foreach (tbl[t]) begin
            bus_wr = tbl[t].wr;
            bus_size = tbl[t].sz;
            rev_in_type = tbl[t].rv;
            buffer_write_en = 1'b1;
            byte_ready = 1'b1;
            step("tbl_write");
            idle_inputs();
            for (int k = 0; k < tbl[t].nb; k++) begin
                check($sformatf("tbl%0d_byte%0d", t, k), {23'h0, byte_valid, byte_out},
                      {23'h0, 1'b1, 8'(tbl[t].exp >> (8 * (tbl[t].nb - 1 - k)))});
                step("tbl_stream");
            end
            check($sformatf("tbl%0d_read_wait", t), {31'h0, read_wait}, 32'h0);
        end

        // Three back-to-back words with the CRC unit stalled.
        byte_ready = 1'b0;
        buffer_write_en = 1'b1;
        bus_size = 2'b10;
        bus_wr = 32'h1111_2222; step("bb_w1");
        bus_wr = 32'h3333_4444; step("bb_w2");
        check("bb_full", {31'h0, buffer_full}, 32'h1);
        bus_wr = 32'h5555_6666;
        step("bb_w3a");
        step("bb_w3b");
        buffer_write_en = 1'b0;
        byte_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && byte_valid; i++) begin
            n++;
            step("bb_drain");
        end
        check("bb_byte_count", n, 8);
        bus_wr = 32'h5555_6666;
        buffer_write_en = 1'b1;
        step("bb_w3_retry");
        buffer_write_en = 1'b0;
        check("bb_w3_first", {24'h0, byte_out}, 32'h55);
        drain_all();

        // Flush while a byte is stalled in handshake with a second entry queued.
        byte_ready = 1'b0;
        bus_wr = 32'hAABB_CCDD;
        buffer_write_en = 1'b1;
        step("fl_w1");
        buffer_write_en = 1'b0;
        byte_ready = 1'b1;
        step("fl_adv");
        byte_ready = 1'b0;
        bus_wr = 32'h1234_5678;
        buffer_write_en = 1'b1;
        step("fl_w2");
        buffer_write_en = 1'b0;
        reset_chain = 1'b1;
        step("fl_req");
        reset_chain = 1'b0;
        check("fl_pending", {31'h0, reset_pending}, 32'h1);
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            step("fl_hold");
            check("fl_held_byte", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'hBB});
            pulses += int'(crc_unit_rst);
        end
        byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("fl_after");
            pulses += int'(crc_unit_rst);
            check("fl_no_more_bytes", {31'h0, byte_valid}, 32'h0);
        end
        check("fl_pulse_count", pulses, 1);

        // Flush with nothing in flight.
        reset_chain = 1'b1;
        step("fl_idle");
        reset_chain = 1'b0;
        check("fl_idle_pulse", {30'h0, crc_unit_rst, reset_pending}, 32'h2);
        step("fl_idle_after");

        // Asynchronous reset in the middle of a word.
        bus_wr = 32'hDEAD_BEEF;
        buffer_write_en = 1'b1;
        step("ar_write");
        buffer_write_en = 1'b0;
        step("ar_mid");
        #2;
        HRESETn = 1'b0;
        #1;
        check("ar_outputs_zero",
              {19'h0, byte_valid, byte_out, buffer_full, read_wait, reset_pending, crc_unit_rst}, 32'h0);
        mq.delete();
        lq.delete();
        m_pend = 1'b0;
        m_rst  = 1'b0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        check_outputs("ar_released");
        bus_wr = 32'h0000_00C3;
        bus_size = 2'b00;
        rev_in_type = 2'b00;
        buffer_write_en = 1'b1;
        step("ar_resume");
        buffer_write_en = 1'b0;
        check("ar_resume_byte", {24'h0, byte_out}, 32'hC3);
        drain_all();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bus_wr          = $urandom;
            bus_size        = 2'($urandom_range(0, 3));
            rev_in_type     = 2'($urandom_range(0, 3));
            buffer_write_en = ($urandom_range(0, 99) < 55);
            byte_ready      = ($urandom_range(0, 99) < 70);
            reset_chain     = ($urandom_range(0, 99) < 3);
            step("random");
        end
        drain_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
